complex_alu_arbiter: RTL and testbench

Shares one complex ALU wrapper (fixed-latency, non-stallable, one op/cycle) between NUM_REQ independent requesters. Round-robin arbitration, registered issue to the ALU, a tag pipeline matched to ALU latency, per-requester response FIFOs with valid/ready, and per-requester credit limiting so returning results are never dropped. Sits between the PE-array control units and the complex ALU.

---
 rtl/complex_alu_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_complex_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_alu_arbiter.sv
// complex_alu_arbiter
// Shares one fixed-latency, non-stallable complex ALU between NUM_REQ
// requesters. A round-robin arbiter picks one request per cycle, and the
// operands are registered onto the ALU port. A tag pipe matched to the ALU
// latency sends each result back to the response FIFO of the requester that
// issued it. Each requester has a credit counter that covers its in-flight
// and buffered results, so a returning result always has a FIFO slot.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : per-requester request handshake (ready is combinational)
//   req_opcode         : 3 bits per requester
//   req_a/b/c          : {real, imag} operands per requester
//   rsp_valid/ready    : per-requester response handshake
//   rsp_data           : head of each response FIFO
//   alu_opcode, alu_valid_in, alu_operand_a/b/c : registered issue to the ALU
//   alu_result, alu_valid_out                   : ALU return path
//   err_opcode         : pulse, an illegal opcode was consumed
//   err_req_id         : requester of the last illegal opcode (held)
//   err_orphan         : pulse, an ALU result arrived with no tag
module complex_alu_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ALU_LATENCY     = 8,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [3*NUM_REQ-1:0]              req_opcode,
  input  logic [2*DATA_WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [2*DATA_WIDTH*NUM_REQ-1:0]   req_b,
  input  logic [2*DATA_WIDTH*NUM_REQ-1:0]   req_c,
  output logic [NUM_REQ-1:0]                rsp_valid,
  input  logic [NUM_REQ-1:0]                rsp_ready,
  output logic [2*DATA_WIDTH*NUM_REQ-1:0]   rsp_data,
  output logic [2:0]                        alu_opcode,
  output logic                              alu_valid_in,
  output logic [2*DATA_WIDTH-1:0]           alu_operand_a,
  output logic [2*DATA_WIDTH-1:0]           alu_operand_b,
  output logic [2*DATA_WIDTH-1:0]           alu_operand_c,
  input  logic [2*DATA_WIDTH-1:0]           alu_result,
  input  logic                              alu_valid_out,
  output logic                              err_opcode,
  output logic [$clog2(NUM_REQ)-1:0]        err_req_id,
  output logic                              err_orphan
);

  localparam int unsigned CW = 2 * DATA_WIDTH;
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned NW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [NW-1:0] CREDIT_MAX = NW'(MAX_OUTSTANDING);
  localparam logic [2:0]    OP_NOP     = 3'b000;
  localparam logic [2:0]    OP_RSV     = 3'b011;

  // Arbitration
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      grant_id;
  logic               grant_valid;
  logic               grant_legal;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] issue_hit;

  // Selected request payload
  logic [2:0]         sel_opcode;
  logic [CW-1:0]      sel_a;
  logic [CW-1:0]      sel_b;
  logic [CW-1:0]      sel_c;

  // Tag pipe aligned to the ALU pipeline
  logic [IW-1:0]          issue_id;
  logic [ALU_LATENCY-1:0] tag_vld;
  logic [IW-1:0]          tag_id [ALU_LATENCY];
  logic                   tail_vld;
  logic [IW-1:0]          tail_id;

  // Credits and response FIFOs
  logic [NW-1:0]      credit   [NUM_REQ];
  logic [NW-1:0]      fifo_cnt [NUM_REQ];
  logic [PW-1:0]      wr_ptr   [NUM_REQ];
  logic [PW-1:0]      rd_ptr   [NUM_REQ];
  logic [CW-1:0]      fifo_mem [NUM_REQ][MAX_OUTSTANDING];
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] credit_over;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // A requester may compete only while it has a free credit
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && !rst && (credit[i] < CREDIT_MAX);
    end
  end

  // Round-robin search starting at rr_ptr and wrapping
  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_valid && eligible[IW'(idx)]) begin
        grant_valid = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  // Payload mux for the winning requester
  always_comb begin
    sel_opcode = '0;
    sel_a      = '0;
    sel_b      = '0;
    sel_c      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        sel_opcode = req_opcode[3*i +: 3];
        sel_a      = req_a[CW*i +: CW];
        sel_b      = req_b[CW*i +: CW];
        sel_c      = req_c[CW*i +: CW];
      end
    end
  end

  assign grant_legal = (sel_opcode != OP_NOP) && (sel_opcode != OP_RSV);
  assign tail_vld    = tag_vld[ALU_LATENCY-1];
  assign tail_id     = tag_id[ALU_LATENCY-1];

  // Per-requester handshake and FIFO control decode
  always_comb begin
    req_ready   = '0;
    issue_hit   = '0;
    push        = '0;
    pop         = '0;
    full        = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    credit_over = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i]   = grant_valid && (grant_id == IW'(i));
      issue_hit[i]   = req_ready[i] && grant_legal;
      rsp_valid[i]   = !rst && (fifo_cnt[i] != '0);
      pop[i]         = rsp_valid[i] && rsp_ready[i];
      push[i]        = alu_valid_out && tail_vld && (tail_id == IW'(i));
      full[i]        = (fifo_cnt[i] == CREDIT_MAX);
      credit_over[i] = (credit[i] > CREDIT_MAX);
      rsp_data[CW*i +: CW] = fifo_mem[i][rd_ptr[i]];
    end
  end

  // Issue register, round-robin pointer and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      alu_valid_in  <= 1'b0;
      alu_opcode    <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_operand_c <= '0;
      issue_id      <= '0;
      err_opcode    <= 1'b0;
      err_req_id    <= '0;
      err_orphan    <= 1'b0;
    end else begin
      alu_valid_in <= grant_valid && grant_legal;
      err_opcode   <= grant_valid && !grant_legal;
      err_orphan   <= alu_valid_out && !tail_vld;
      if (grant_valid) begin
        rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
      end
      if (grant_valid && grant_legal) begin
        alu_opcode    <= sel_opcode;
        alu_operand_a <= sel_a;
        alu_operand_b <= sel_b;
        alu_operand_c <= sel_c;
        issue_id      <= grant_id;
      end
      if (grant_valid && !grant_legal) begin
        err_req_id <= grant_id;
      end
    end
  end

  // Tag pipe: stage 0 captures the issue that is on the ALU port this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int unsigned s = 0; s < ALU_LATENCY; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_vld[0] <= alu_valid_in;
      tag_id[0]  <= issue_id;
      for (int unsigned s = 1; s < ALU_LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  // Credits and response FIFOs; a simultaneous issue and pop cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        credit[i]   <= '0;
        fifo_cnt[i] <= '0;
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        for (int unsigned j = 0; j < MAX_OUTSTANDING; j++) begin
          fifo_mem[i][j] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (issue_hit[i] && !pop[i]) begin
          credit[i] <= credit[i] + NW'(1);
        end else if (pop[i] && !issue_hit[i]) begin
          credit[i] <= credit[i] - NW'(1);
        end

        if (push[i]) begin
          fifo_mem[i][wr_ptr[i]] <= alu_result;
          wr_ptr[i]              <= ptr_inc(wr_ptr[i]);
        end
        if (pop[i]) begin
          rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        end

        if (push[i] && !pop[i]) begin
          fifo_cnt[i] <= fifo_cnt[i] + NW'(1);
        end else if (pop[i] && !push[i]) begin
          fifo_cnt[i] <= fifo_cnt[i] - NW'(1);
        end
      end
    end
  end

  // Credit accounting guarantees a slot for every returning result
  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push & full & ~pop) == '0);

  credit_in_range: assert property (@(posedge clk) disable iff (rst)
    credit_over == '0);

endmodule

// File: tb/tb_complex_alu_arbiter.sv
// Directed bench for complex_alu_arbiter with a behavioural 8-cycle complex ALU.
module tb_complex_alu_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 16;
  localparam int unsigned CW      = 2 * DW;
  localparam int unsigned LAT     = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [3*NUM_REQ-1:0]      req_opcode;
  logic [CW*NUM_REQ-1:0]     req_a;
  logic [CW*NUM_REQ-1:0]     req_b;
  logic [CW*NUM_REQ-1:0]     req_c;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [CW*NUM_REQ-1:0]     rsp_data;
  logic [2:0]                alu_opcode;
  logic                      alu_valid_in;
  logic [CW-1:0]             alu_operand_a;
  logic [CW-1:0]             alu_operand_b;
  logic [CW-1:0]             alu_operand_c;
  logic [CW-1:0]             alu_result;
  logic                      alu_valid_out;
  logic                      err_opcode;
  logic [1:0]                err_req_id;
  logic                      err_orphan;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  complex_alu_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ALU_LATENCY(LAT), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_opcode(alu_opcode), .alu_valid_in(alu_valid_in),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_operand_c(alu_operand_c),
    .alu_result(alu_result), .alu_valid_out(alu_valid_out),
    .err_opcode(err_opcode), .err_req_id(err_req_id), .err_orphan(err_orphan)
  );

  // Behavioural complex ALU: not reset, so in-flight work survives a DUT reset
  function automatic logic [CW-1:0] cmul(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic signed [15:0] ar, ai, br, bi;
    logic signed [31:0] re, im;
    ar = a[31:16]; ai = a[15:0]; br = b[31:16]; bi = b[15:0];
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {re[15:0], im[15:0]};
  endfunction

  function automatic logic [CW-1:0] alu_model(input logic [2:0] op, input logic [CW-1:0] a,
                                              input logic [CW-1:0] b, input logic [CW-1:0] c);
    logic [CW-1:0] p;
    p = cmul(a, b);
    case (op)
      3'b001: return {16'(a[31:16] + b[31:16]), 16'(a[15:0] + b[15:0])};
      3'b010: return {16'(a[31:16] - b[31:16]), 16'(a[15:0] - b[15:0])};
      3'b100: return p;
      3'b101: return {16'(p[31:16] + c[31:16]), 16'(p[15:0] + c[15:0])};
      3'b110: return {16'(p[31:16] - c[31:16]), 16'(p[15:0] - c[15:0])};
      3'b111: return {($signed(a[31:16]) > $signed(b[31:16])) ? a[31:16] : b[31:16],
                      ($signed(a[15:0])  > $signed(b[15:0]))  ? a[15:0]  : b[15:0]};
      default: return '0;
    endcase
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [CW-1:0]  pd [LAT];

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], alu_valid_in};
    pd[0] <= alu_model(alu_opcode, alu_operand_a, alu_operand_b, alu_operand_c);
    for (int s = 1; s < LAT; s++) pd[s] <= pd[s-1];
  end

  assign alu_valid_out = pv[LAT-1];
  assign alu_result    = pd[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [CW-1:0] a,
                         input logic [CW-1:0] b, input logic [CW-1:0] c);
    req_opcode[3*i +: 3] = op;
    req_a[CW*i +: CW]    = a;
    req_b[CW*i +: CW]    = b;
    req_c[CW*i +: CW]    = c;
  endtask

  logic [127:0]       exp_data;
  logic [NUM_REQ-1:0] seen_rsp;
  logic               seen_issue;
  int                 orphans;

  initial begin
    rst = 1'b1; req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0; req_c = '0;
    rsp_ready = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_alu_valid_in", 128'(alu_valid_in), 128'(0));
    chk("rst_alu_opcode",   128'(alu_opcode),   128'(0));
    chk("rst_operand_a",    128'(alu_operand_a), 128'(0));
    chk("rst_rsp_valid",    128'(rsp_valid),    128'(0));
    chk("rst_err_opcode",   128'(err_opcode),   128'(0));
    chk("rst_err_orphan",   128'(err_orphan),   128'(0));
    chk("rst_err_req_id",   128'(err_req_id),   128'(0));
    for (int i = 0; i < 4; i++) set_req(i, 3'b001, 32'h0001_0001, 32'h0, 32'h0);
    req_valid = 4'hF;
    #1 chk("rst_req_ready", 128'(req_ready), 128'(0));
    req_valid = '0;

    // Single MUL on req0: {3,2}*{1,4} = {-5,14}
    rst = 1'b0;
    set_req(0, 3'b100, {16'd3, 16'd2}, {16'd1, 16'd4}, 32'h0);
    req_valid = 4'b0001;
    #1 chk("single_grant", 128'(req_ready), 128'(4'b0001));
    tick(); req_valid = '0;
    chk("single_issue_valid", 128'(alu_valid_in),  128'(1));
    chk("single_issue_op",    128'(alu_opcode),    128'(3'b100));
    chk("single_issue_a",     128'(alu_operand_a), 128'(32'h0003_0002));
    chk("single_issue_b",     128'(alu_operand_b), 128'(32'h0001_0004));
    tick();
    chk("single_issue_once", 128'(alu_valid_in), 128'(0));
    repeat (7) tick();
    chk("single_rsp_early", 128'(rsp_valid), 128'(0));
    tick();
    chk("single_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
    chk("single_rsp_data",  128'(rsp_data[31:0]), 128'(32'hFFFB_000E));
    rsp_ready = 4'b0001;
    tick(); rsp_ready = '0;
    chk("single_popped", 128'(rsp_valid), 128'(0));
    chk("single_no_orphan", 128'(err_orphan), 128'(0));

    // Illegal opcode on req1
    set_req(1, 3'b011, 32'h1234_5678, 32'h1, 32'h2);
    req_valid = 4'b0010;
    #1 chk("illegal_grant", 128'(req_ready), 128'(4'b0010));
    tick(); req_valid = '0;
    chk("illegal_err_pulse", 128'(err_opcode),   128'(1));
    chk("illegal_err_id",    128'(err_req_id),   128'(1));
    chk("illegal_no_issue",  128'(alu_valid_in), 128'(0));
    tick();
    chk("illegal_err_clear", 128'(err_opcode), 128'(0));
    chk("illegal_id_held",   128'(err_req_id), 128'(1));
    seen_rsp = '0; seen_issue = 1'b0;
    repeat (10) begin
      tick();
      seen_rsp   |= rsp_valid;
      seen_issue |= alu_valid_in;
    end
    chk("illegal_no_rsp",   128'(seen_rsp),   128'(0));
    chk("illegal_no_alu",   128'(seen_issue), 128'(0));

    // Round-robin from rr_ptr=2 with all four requesting ADD {i,r}+{100,200}
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++)
        set_req(i, 3'b001, {16'(i), 16'(k / 4)}, {16'd100, 16'd200}, 32'h0);
      req_valid = 4'hF;
      #1 chk("rr_grant", 128'(req_ready), 128'(4'b0001 << ((2 + k) % 4)));
      tick();
    end
    #1 chk("rr_credit_limit", 128'(req_ready), 128'(0));
    req_valid = '0;
    repeat (10) tick();
    chk("rr_rsp_valid0", 128'(rsp_valid), 128'(4'hF));
    exp_data = '0;
    for (int i = 0; i < 4; i++) exp_data[32*i +: 32] = {16'(i + 100), 16'd200};
    chk("rr_rsp_data0", rsp_data, exp_data);
    rsp_ready = 4'hF;
    tick();
    for (int i = 0; i < 4; i++) exp_data[32*i +: 32] = {16'(i + 100), 16'd201};
    chk("rr_rsp_valid1", 128'(rsp_valid), 128'(4'hF));
    chk("rr_rsp_data1", rsp_data, exp_data);
    tick(); rsp_ready = '0;
    chk("rr_drained", 128'(rsp_valid), 128'(0));

    // Credit stall on req2 with rsp_ready low
    set_req(2, 3'b001, {16'd1, 16'd1}, 32'h0, 32'h0);
    req_valid = 4'b0100;
    #1 chk("stall_g0", 128'(req_ready), 128'(4'b0100));
    tick(); set_req(2, 3'b001, {16'd2, 16'd2}, 32'h0, 32'h0);
    #1 chk("stall_g1", 128'(req_ready), 128'(4'b0100));
    tick(); set_req(2, 3'b001, {16'd3, 16'd3}, 32'h0, 32'h0);
    #1 chk("stall_blocked", 128'(req_ready), 128'(0));
    repeat (9) tick();
    chk("stall_still_blocked", 128'(req_ready), 128'(0));
    chk("stall_rsp_valid", 128'(rsp_valid), 128'(4'b0100));
    chk("stall_rsp_head0", 128'(rsp_data[95:64]), 128'(32'h0001_0001));
    rsp_ready = 4'b0100;
    #1 chk("stall_pop_cycle_blocked", 128'(req_ready), 128'(0));
    tick();
    chk("stall_resume", 128'(req_ready), 128'(4'b0100));
    chk("stall_rsp_head1", 128'(rsp_data[95:64]), 128'(32'h0002_0002));
    tick();
    chk("stall_fifo_empty", 128'(rsp_valid), 128'(0));
    set_req(2, 3'b001, {16'd4, 16'd4}, 32'h0, 32'h0);
    #1 chk("stall_issue_pop_credit", 128'(req_ready), 128'(4'b0100));
    tick();
    chk("stall_credit_full", 128'(req_ready), 128'(0));
    req_valid = '0;
    repeat (8) tick();
    chk("stall_rsp3_valid", 128'(rsp_valid), 128'(4'b0100));
    chk("stall_rsp3_data", 128'(rsp_data[95:64]), 128'(32'h0003_0003));
    tick();
    chk("stall_rsp4_valid", 128'(rsp_valid), 128'(4'b0100));
    chk("stall_rsp4_data", 128'(rsp_data[95:64]), 128'(32'h0004_0004));
    tick(); rsp_ready = '0;
    chk("stall_no_loss_end", 128'(rsp_valid), 128'(0));

    // Mid-flight reset: three issues (ptr=3 -> 3,0,1), reset one cycle at T+4
    set_req(0, 3'b100, {16'd2, 16'd0}, {16'd0, 16'd2}, 32'h0);
    set_req(1, 3'b101, {16'd1, 16'd1}, {16'd1, 16'd1}, {16'd5, 16'd5});
    set_req(3, 3'b111, {16'd7, 16'd1}, {16'd2, 16'd9}, 32'h0);
    req_valid = 4'b1011;
    #1 chk("mf_g0", 128'(req_ready), 128'(4'b1000));
    tick();
    chk("mf_g1", 128'(req_ready), 128'(4'b0001));
    tick();
    chk("mf_g2", 128'(req_ready), 128'(4'b0010));
    tick(); req_valid = '0;
    tick();
    rst = 1'b1; req_valid = 4'b1011;
    #1 chk("mf_rst_ready", 128'(req_ready), 128'(0));
    chk("mf_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    tick();
    chk("mf_rst_alu_valid", 128'(alu_valid_in), 128'(0));
    chk("mf_rst_alu_op",    128'(alu_opcode),   128'(0));
    chk("mf_rst_operand_a", 128'(alu_operand_a), 128'(0));
    chk("mf_rst_err_id",    128'(err_req_id),   128'(0));
    rst = 1'b0; req_valid = '0;
    orphans = 0; seen_rsp = '0;
    repeat (12) begin
      tick();
      orphans  += int'(err_orphan);
      seen_rsp |= rsp_valid;
    end
    chk("mf_orphans", 128'(orphans), 128'(3));
    chk("mf_no_rsp", 128'(seen_rsp), 128'(0));

    // Pointer restarts at requester 0 after reset
    for (int i = 0; i < 4; i++) set_req(i, 3'b001, 32'h0, 32'h0, 32'h0);
    req_valid = 4'hF;
    #1 chk("post_rst_ptr", 128'(req_ready), 128'(4'b0001));
    req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
